// File: rtl/reservation_station.sv
// reservation_station
// Per-functional-unit instruction buffer feeding issue_unit. Holds dispatched
// instructions until both source operands are available (either at dispatch
// or via a CDB broadcast), then offers the lowest-index ready entry for issue.
//
// Optional build macro: RS_WAKEUP_BYPASS_EN
//   When defined, a CDB broadcast also wakes entries combinationally, so an
//   entry whose last missing operand is on the CDB this cycle can be selected
//   (and granted) in the same cycle, with cdb_value muxed into out_srcX.
//
// Ports:
//   clk, reset (async, active high), flush (sync clear of all entries)
//   dispatch_*      : new instruction with renamed sources and dest ROB tag
//   rs_full         : every entry valid; dispatch is dropped
//   cdb_*           : result broadcast (tag/value) for operand wakeup
//   issue_grant     : issue_unit takes the selected entry this cycle
//   instr_ready     : some entry has both operands
//   out_ROB_tag/op/src1/src2 : selected entry (all zero when !instr_ready)
//   entry_count     : registered number of valid entries

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module reservation_station #(
  parameter int RS_SIZE = 4,
  parameter int XLEN    = 32,
  parameter int OP_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  input  logic [OP_LEN-1:0]           dispatch_op,
  input  logic                        dispatch_src1_valid,
  input  logic [`ROB_TAG_LEN-1:0]     dispatch_src1_tag,
  input  logic [XLEN-1:0]             dispatch_src1_value,
  input  logic                        dispatch_src2_valid,
  input  logic [`ROB_TAG_LEN-1:0]     dispatch_src2_tag,
  input  logic [XLEN-1:0]             dispatch_src2_value,
  input  logic [`ROB_TAG_LEN-1:0]     dispatch_dest_tag,
  output logic                        rs_full,
  input  logic                        cdb_valid,
  input  logic [`ROB_TAG_LEN-1:0]     cdb_tag,
  input  logic [XLEN-1:0]             cdb_value,
  input  logic                        issue_grant,
  output logic                        instr_ready,
  output logic [`ROB_TAG_LEN-1:0]     out_ROB_tag,
  output logic [OP_LEN-1:0]           out_op,
  output logic [XLEN-1:0]             out_src1,
  output logic [XLEN-1:0]             out_src2,
  output logic [$clog2(RS_SIZE):0]    entry_count
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  // Entry storage
  logic [RS_SIZE-1:0]      valid_reg;
  logic [RS_SIZE-1:0]      s1_rdy_reg;
  logic [RS_SIZE-1:0]      s2_rdy_reg;
  logic [OP_LEN-1:0]       op_reg     [RS_SIZE];
  logic [`ROB_TAG_LEN-1:0] s1_tag_reg [RS_SIZE];
  logic [`ROB_TAG_LEN-1:0] s2_tag_reg [RS_SIZE];
  logic [XLEN-1:0]         s1_val_reg [RS_SIZE];
  logic [XLEN-1:0]         s2_val_reg [RS_SIZE];
  logic [`ROB_TAG_LEN-1:0] dest_reg   [RS_SIZE];
  logic [CNT_W-1:0]        count_reg;

  // Per-entry wakeup match and the operand view used for selection
  logic [RS_SIZE-1:0]      s1_hit;
  logic [RS_SIZE-1:0]      s2_hit;
  logic [RS_SIZE-1:0]      s1_rdy_eff;
  logic [RS_SIZE-1:0]      s2_rdy_eff;
  logic [XLEN-1:0]         s1_val_eff [RS_SIZE];
  logic [XLEN-1:0]         s2_val_eff [RS_SIZE];
  logic [RS_SIZE-1:0]      ready;

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign s1_hit[gi] = cdb_valid && (s1_tag_reg[gi] == cdb_tag);
      assign s2_hit[gi] = cdb_valid && (s2_tag_reg[gi] == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      // Same-cycle wakeup: a matching broadcast counts as a ready operand now.
      assign s1_rdy_eff[gi] = s1_rdy_reg[gi] | s1_hit[gi];
      assign s2_rdy_eff[gi] = s2_rdy_reg[gi] | s2_hit[gi];
      assign s1_val_eff[gi] = s1_rdy_reg[gi] ? s1_val_reg[gi] : cdb_value;
      assign s2_val_eff[gi] = s2_rdy_reg[gi] ? s2_val_reg[gi] : cdb_value;
`else
      assign s1_rdy_eff[gi] = s1_rdy_reg[gi];
      assign s2_rdy_eff[gi] = s2_rdy_reg[gi];
      assign s1_val_eff[gi] = s1_val_reg[gi];
      assign s2_val_eff[gi] = s2_val_reg[gi];
`endif
      assign ready[gi] = valid_reg[gi] & s1_rdy_eff[gi] & s2_rdy_eff[gi];
    end
  endgenerate

  // Lowest-index ready entry for issue, lowest-index free entry for dispatch.
  logic             any_ready;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid_reg[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign rs_full     = &valid_reg;
  assign entry_count = count_reg;
  assign instr_ready = any_ready;
  assign out_ROB_tag = any_ready ? dest_reg[sel_idx]   : '0;
  assign out_op      = any_ready ? op_reg[sel_idx]     : '0;
  assign out_src1    = any_ready ? s1_val_eff[sel_idx] : '0;
  assign out_src2    = any_ready ? s2_val_eff[sel_idx] : '0;

  // Fullness is judged on registered state, so a same-cycle grant never
  // makes room for a dispatch.
  logic accept;
  logic issue_fire;
  logic d1_hit;
  logic d2_hit;

  assign accept     = dispatch_valid & ~rs_full;
  assign issue_fire = issue_grant & any_ready;
  // A source broadcast in the dispatch cycle would otherwise be missed forever.
  assign d1_hit     = cdb_valid && (dispatch_src1_tag == cdb_tag);
  assign d2_hit     = cdb_valid && (dispatch_src2_tag == cdb_tag);

  // Occupancy: the only state that needs reset/flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (issue_fire && (sel_idx == IDX_W'(i))) valid_reg[i] <= 1'b0;
        if (accept && (free_idx == IDX_W'(i)))    valid_reg[i] <= 1'b1;
      end
      count_reg <= count_reg + CNT_W'(accept) - CNT_W'(issue_fire);
    end
  end

  // Payload: only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (valid_reg[i] && !s1_rdy_reg[i] && s1_hit[i]) begin
        s1_rdy_reg[i] <= 1'b1;
        s1_val_reg[i] <= cdb_value;
      end
      if (valid_reg[i] && !s2_rdy_reg[i] && s2_hit[i]) begin
        s2_rdy_reg[i] <= 1'b1;
        s2_val_reg[i] <= cdb_value;
      end
      if (accept && (free_idx == IDX_W'(i))) begin
        op_reg[i]     <= dispatch_op;
        dest_reg[i]   <= dispatch_dest_tag;
        s1_tag_reg[i] <= dispatch_src1_tag;
        s2_tag_reg[i] <= dispatch_src2_tag;
        s1_rdy_reg[i] <= dispatch_src1_valid | d1_hit;
        s2_rdy_reg[i] <= dispatch_src2_valid | d2_hit;
        s1_val_reg[i] <= dispatch_src1_valid ? dispatch_src1_value
                       : (d1_hit ? cdb_value : dispatch_src1_value);
        s2_val_reg[i] <= dispatch_src2_valid ? dispatch_src2_value
                       : (d2_hit ? cdb_value : dispatch_src2_value);
      end
    end
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Per-FU-class instruction buffer sitting directly upstream of issue_unit, one instance per functional unit (integer, branch, load/store, mult).
- Accepts dispatched instructions with renamed operands and snoops the CDB for outstanding source tags.
- Raises instr_ready to issue_unit when any entry has both operands, and presents the ROB tag and operands of the selected entry.
- Frees that entry when issue_unit grants it.

Parameters:
- RS_SIZE, 4, number of entries (power of two, 2..16)
- XLEN, 32, operand/value width
- OP_LEN, 4, opcode field width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all entries (branch mispredict)
- dispatch_valid  in  1  new instruction presented
- dispatch_op  in  OP_LEN  FU opcode
- dispatch_src1_valid  in  1  src1 value present (else waiting on tag)
- dispatch_src1_tag  in  `ROB_TAG_LEN  producer tag of src1
- dispatch_src1_value  in  XLEN  src1 value
- dispatch_src2_valid / dispatch_src2_tag / dispatch_src2_value  in  1 / `ROB_TAG_LEN / XLEN  same as src1, for src2
- dispatch_dest_tag  in  `ROB_TAG_LEN  ROB tag of this instruction
- rs_full  out  1  all entries valid; dispatch ignored
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  `ROB_TAG_LEN  broadcast ROB tag
- cdb_value  in  XLEN  broadcast result
- issue_grant  in  1  issue_unit takes the selected entry this cycle
- instr_ready  out  1  at least one entry ready (to issue_unit instr_ready[k])
- out_ROB_tag  out  `ROB_TAG_LEN  dest tag of selected entry (to issue_unit in_ROB_tag[k])
- out_op  out  OP_LEN  opcode of selected entry
- out_src1  out  XLEN  src1 value of selected entry
- out_src2  out  XLEN  src2 value of selected entry
- entry_count  out  $clog2(RS_SIZE)+1  number of valid entries

Behaviour:
- Reset (async) clears all valid bits. Outputs go to: rs_full=0, instr_ready=0, entry_count=0, out_* =0. out_* are driven 0 whenever instr_ready=0.
- Entry state: valid, op, per-source {rdy, tag, value}, dest_tag. Entry ready = valid & src1.rdy & src2.rdy.
- Dispatch: accepted iff dispatch_valid & !rs_full. rs_full comes from registered state, so a same-cycle grant does not free room for dispatch. Dispatch while full is dropped, with no state change.
  - Accepted instruction is written to the lowest-index invalid entry at the clock edge.
- Dispatch/CDB capture: if cdb_valid and cdb_tag equals a not-valid dispatch source tag in the same cycle, that source is written with rdy=1 and value=cdb_value. This is mandatory for correctness.
- Wakeup: every valid entry with a non-ready source whose tag == cdb_tag while cdb_valid sets rdy=1 and value=cdb_value at the clock edge. Both sources can wake on one broadcast.
- Selection: lowest-index ready entry, combinational from registered state. instr_ready, out_ROB_tag, out_op, out_src1 and out_src2 reflect it.
- Issue: if issue_grant & instr_ready, the selected entry's valid clears at the clock edge. issue_grant while instr_ready=0 is ignored.
- Latency:
  - Dispatch with both operands ready: instr_ready=1 the next cycle.
  - Wakeup by CDB in cycle N: eligible in cycle N+1.
- Simultaneous events in one edge:
  - Dispatch + grant: both take effect; entry_count is unchanged.
  - Wakeup + grant of a different entry: both take effect.
- Flush: all valid bits clear at the edge. It overrides same-cycle dispatch and grant. Outputs next cycle equal the reset values.
- entry_count = popcount(valid), registered. It is never greater than RS_SIZE.

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- With the macro defined: CDB wakeup is also applied combinationally to selection. An entry whose last missing source matches cdb_tag in cycle N is eligible in cycle N. out_srcX muxes in cdb_value, and a grant in cycle N issues it.
- Without the macro: wakeup is visible only from N+1, as described in Behaviour.

Test Plan:
- Reset, then dispatch op=3 with src1=5 and src2=7 both valid, dest_tag=2 -> next cycle instr_ready=1, out_ROB_tag=2, out_src1=5, out_src2=7. issue_grant -> following cycle instr_ready=0, entry_count=0.
- Dispatch with src1 waiting on tag 6; CDB tag=6 value=0x55 in cycle N -> instr_ready=1 at N+1 with out_src1=0x55, or at N with RS_WAKEUP_BYPASS_EN.
- Dispatch with src2 tag 9 in the same cycle as CDB tag=9 value=0xAA -> entry ready next cycle, out_src2=0xAA.
- Fill RS_SIZE=4 entries -> rs_full=1, entry_count=4. A fifth dispatch with grant in the same cycle is dropped -> entry_count=3.
- Entries 1 and 3 ready, entry 0 waiting -> out_ROB_tag equals entry 1's tag. After grant, entry 3 is selected.
- Three valid entries, then flush together with dispatch_valid and issue_grant -> next cycle entry_count=0, instr_ready=0, rs_full=0.
